// File: rtl/serial_port_pkg.sv
// Shared definitions for the serial_port UART block.
//   - uart_state_t : TX/RX FSM encodings (IDLE=0, START=1, DATA=2, STOP=3)
//   - DATA_BITS    : payload bits per frame (8N1)
//   - COM_*_ADDR   : memory-controller window for the UART data/status
//                    registers, shared by the controller and this block
package serial_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;

    localparam logic [31:0] COM_DATA_ADDR = 32'h1FD0_03F8;
    localparam logic [31:0] COM_STAT_ADDR = 32'h1FD0_03FC;

endpackage

// File: rtl/uart_baud_cnt.sv
// Down-counting baud timer, one instance per direction.
//   clk      : system clock
//   rst      : synchronous active-high reset (count clears to 0)
//   load     : reload the counter with load_val (takes priority)
//   load_val : reload value
//   en       : count enable; expire is only asserted while enabled
//   expire   : combinational pulse, counter at 0 while enabled
module uart_baud_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign expire = en && (cnt == '0);

endmodule

// File: rtl/serial_port.sv
// 8N1 UART transceiver behind the memory controller's COM window.
//   clk50M, rst          : clock, synchronous active-high reset
//   tx_data, tx_start    : byte to send and its one-cycle write strobe
//   write_ready          : transmitter idle, tx_start will be accepted
//   rx_data, read_ready  : last received byte, unread-byte flag
//   int_ack              : CPU read acknowledge (rising edge is used)
//   int_com              : interrupt request, mirrors read_ready
//   overrun              : sticky, byte arrived while read_ready was set
//   frame_err            : one-cycle pulse when a stop bit samples low
//   rxd, txd             : serial line in (asynchronous) / out, idle high
module serial_port
    import serial_port_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk50M,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       write_ready,
    output logic [7:0] rx_data,
    output logic       read_ready,
    input  logic       int_ack,
    output logic       int_com,
    output logic       overrun,
    output logic       frame_err,
    input  logic       rxd,
    output logic       txd
);

    localparam int DIVISOR = CLK_FREQ / BAUD;
    localparam int CNT_W   = $clog2(DIVISOR);

    // Counter expires when it reaches 0, so a full bit reloads DIVISOR-1.
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(DIVISOR / 2);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    // ---------------- transmitter ----------------
    uart_state_t tx_state;
    logic [7:0]  tx_byte;
    logic [2:0]  tx_idx;
    logic        tx_exp;
    logic        tx_load;

    assign tx_load = ((tx_state == ST_IDLE) && tx_start) || tx_exp;

    uart_baud_cnt #(.W(CNT_W)) u_tx_cnt (
        .clk      (clk50M),
        .rst      (rst),
        .load     (tx_load),
        .load_val (FULL_BIT),
        .en       (tx_state != ST_IDLE),
        .expire   (tx_exp)
    );

    always_ff @(posedge clk50M) begin
        if (rst) begin
            tx_state    <= ST_IDLE;
            tx_byte     <= '0;
            tx_idx      <= '0;
            txd         <= 1'b1;
            write_ready <= 1'b1;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (tx_start) begin
                        tx_byte     <= tx_data;
                        tx_idx      <= '0;
                        txd         <= 1'b0;
                        write_ready <= 1'b0;
                        tx_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_exp) begin
                        txd      <= tx_byte[0];
                        tx_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tx_exp) begin
                        // index wraps back to 0 after the last bit
                        tx_idx <= tx_idx + 3'd1;
                        if (tx_idx == LAST_BIT) begin
                            txd      <= 1'b1;
                            tx_state <= ST_STOP;
                        end else begin
                            txd <= tx_byte[tx_idx + 3'd1];
                        end
                    end
                end
                ST_STOP: begin
                    if (tx_exp) begin
                        write_ready <= 1'b1;
                        tx_state    <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic rxs_meta, rxs, rxs_prev;
    logic ack_d;

    always_ff @(posedge clk50M) begin
        if (rst) begin
            rxs_meta <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
            ack_d    <= 1'b0;
        end else begin
            rxs_meta <= rxd;
            rxs      <= rxs_meta;
            rxs_prev <= rxs;
            ack_d    <= int_ack;
        end
    end

    logic ack_rise;
    logic rx_fall;
    assign ack_rise = int_ack && !ack_d;
    assign rx_fall  = rxs_prev && !rxs;

    uart_state_t      rx_state;
    logic [7:0]       rx_shift;
    logic [2:0]       rx_idx;
    logic             rx_exp;
    logic             rx_load;
    logic [CNT_W-1:0] rx_load_val;

    // The first reload after the start edge is half a bit so every later
    // sample lands mid-bit.
    assign rx_load     = ((rx_state == ST_IDLE) && rx_fall) || rx_exp;
    assign rx_load_val = (rx_state == ST_IDLE) ? HALF_BIT : FULL_BIT;

    uart_baud_cnt #(.W(CNT_W)) u_rx_cnt (
        .clk      (clk50M),
        .rst      (rst),
        .load     (rx_load),
        .load_val (rx_load_val),
        .en       (rx_state != ST_IDLE),
        .expire   (rx_exp)
    );

    always_ff @(posedge clk50M) begin
        if (rst) begin
            rx_state   <= ST_IDLE;
            rx_shift   <= '0;
            rx_idx     <= '0;
            rx_data    <= '0;
            read_ready <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (ack_rise) begin
                read_ready <= 1'b0;
                overrun    <= 1'b0;
            end
            case (rx_state)
                ST_IDLE: begin
                    if (rx_fall)
                        rx_state <= ST_START;
                end
                ST_START: begin
                    if (rx_exp) begin
                        rx_idx   <= '0;
                        // line back high at mid start bit: glitch, drop it
                        rx_state <= rxs ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (rx_exp) begin
                        rx_shift <= {rxs, rx_shift[7:1]};
                        rx_idx   <= rx_idx + 3'd1;
                        if (rx_idx == LAST_BIT)
                            rx_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Leave at mid stop bit so a back-to-back start edge
                    // is not missed.
                    if (rx_exp) begin
                        rx_state <= ST_IDLE;
                        if (rxs) begin
                            // completion overrides a simultaneous ack
                            rx_data    <= rx_shift;
                            read_ready <= 1'b1;
                            if (!ack_rise)
                                overrun <= overrun | read_ready;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign int_com = read_ready;

endmodule
